smu_cfg_ctrl: RTL and testbench

// Configuration controller for the M parallel smu_unit instances inside smu.

---
 rtl/smu_cfg_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_smu_cfg_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/smu_cfg_ctrl.sv
// smu_cfg_ctrl: beat-stream config loader for the smu_unit array.
// Shadow table is assembled from WRITE commands and committed atomically.
module smu_cfg_ctrl #(
  parameter int N  = 2,
  parameter int K  = 4,
  parameter int M  = 6,
  parameter int DW = 8,
  parameter int SW = (N > 1) ? $clog2(N) : 1,
  parameter int UW = (M > 1) ? $clog2(M) : 1,
  parameter int CW = 2*K + 1 + SW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [DW-1:0]   cfg_data,
  input  logic            cfg_last,
  input  logic [M*SW-1:0] smu_state,
  output logic [M*CW-1:0] cfg_smu,
  output logic [M-1:0]    smu_clr,
  output logic            cfg_locked,
  output logic            cfg_err
);

  localparam int BEATS = (CW + DW - 1) / DW;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_CMT = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_LCK = 2'b11;

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_COMMIT,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CW-1:0]   r_shadow [M][N];
  logic [CW-1:0]   r_active [M][N];
  logic [CW-1:0]   r_stage;
  logic [CW-1:0]   w_stage_nxt;
  logic [CNTW-1:0] r_cnt;
  logic [UW-1:0]   r_unit;
  logic [SW-1:0]   r_st;
  logic            r_locked;
  logic            r_err;
  logic [M-1:0]    r_clr;

  logic            w_acc;
  logic [1:0]      w_op;
  logic [SW-1:0]   w_st;
  logic [UW-1:0]   w_un;
  logic            w_idx_ok;
  logic            w_last_beat;

  logic w_hdr_cap;
  logic w_stage_ld;
  logic w_cnt_inc;
  logic w_wr_shadow;
  logic w_clr_shadow;
  logic w_commit;
  logic w_set_lock;
  logic w_set_err;

  assign w_acc       = cfg_valid & cfg_ready;
  assign w_op        = cfg_data[1:0];
  assign w_st        = cfg_data[SW+1:2];
  assign w_un        = cfg_data[UW+SW+1:SW+2];
  assign w_idx_ok    = (32'(w_un) < M) && (32'(w_st) < N);
  assign w_last_beat = (r_cnt == CNTW'(BEATS-1));

  assign cfg_locked = r_locked;
  assign cfg_err    = r_err;
  assign smu_clr    = r_clr;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_nxt;
  end

  // Next-state decode, handshake and datapath strobes
  always_comb begin
    w_nxt        = r_state;
    cfg_ready    = 1'b1;
    w_hdr_cap    = 1'b0;
    w_stage_ld   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_wr_shadow  = 1'b0;
    w_clr_shadow = 1'b0;
    w_commit     = 1'b0;
    w_set_lock   = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      S_HDR: begin
        if (w_acc) begin
          unique case (w_op)
            OP_WR: begin
              if (!cfg_last && w_idx_ok && !r_locked) begin
                w_hdr_cap = 1'b1;
                w_nxt     = S_PAYLOAD;
              end else begin
                w_set_err = 1'b1;
                w_nxt     = cfg_last ? S_HDR : S_DROP;
              end
            end
            OP_CMT: begin
              if (cfg_last && w_idx_ok && !r_locked) begin
                w_nxt = S_COMMIT;
              end else begin
                w_set_err = 1'b1;
                w_nxt     = cfg_last ? S_HDR : S_DROP;
              end
            end
            OP_CLR: begin
              if (cfg_last && w_idx_ok && !r_locked) begin
                w_clr_shadow = 1'b1;
              end else begin
                w_set_err = 1'b1;
                w_nxt     = cfg_last ? S_HDR : S_DROP;
              end
            end
            OP_LCK: begin
              if (cfg_last && w_idx_ok) begin
                w_set_lock = 1'b1;
              end else begin
                w_set_err = 1'b1;
                w_nxt     = cfg_last ? S_HDR : S_DROP;
              end
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (w_acc) begin
          w_stage_ld = 1'b1;
          if (w_last_beat) begin
            if (cfg_last) begin
              w_wr_shadow = 1'b1;
              w_nxt       = S_HDR;
            end else begin
              w_set_err = 1'b1;
              w_nxt     = S_DROP;
            end
          end else if (cfg_last) begin
            w_set_err = 1'b1;
            w_nxt     = S_HDR;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        cfg_ready = 1'b0;
        w_commit  = 1'b1;
        w_nxt     = S_HDR;
      end
      S_DROP: begin
        if (w_acc && cfg_last) w_nxt = S_HDR;
      end
    endcase
  end

  // Merge the current payload beat into the staging word
  always_comb begin
    w_stage_nxt = r_stage;
    for (int i = 0; i < CW; i++) begin
      if (i / DW == int'(r_cnt)) w_stage_nxt[i] = cfg_data[i % DW];
    end
  end

  // Command capture, staging, status flags and clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage  <= '0;
      r_cnt    <= '0;
      r_unit   <= '0;
      r_st     <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_clr    <= '0;
    end else begin
      if (w_hdr_cap) begin
        r_unit <= w_un;
        r_st   <= w_st;
        r_cnt  <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_stage_ld) r_stage  <= w_stage_nxt;
      if (w_set_lock) r_locked <= 1'b1;
      if (w_set_err)  r_err    <= 1'b1;
      r_clr <= w_commit ? '1 : '0;
    end
  end

  // Shadow and active tables; commit copies every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < M; m++) begin
        for (int s = 0; s < N; s++) begin
          r_shadow[m][s] <= '0;
          r_active[m][s] <= '0;
        end
      end
    end else begin
      if (w_clr_shadow) begin
        for (int m = 0; m < M; m++) begin
          for (int s = 0; s < N; s++) r_shadow[m][s] <= '0;
        end
      end else if (w_wr_shadow) begin
        r_shadow[r_unit][r_st] <= w_stage_nxt;
      end
      if (w_commit) begin
        for (int m = 0; m < M; m++) begin
          for (int s = 0; s < N; s++) r_active[m][s] <= r_shadow[m][s];
        end
      end
    end
  end

  // Per-unit view of the active table; out-of-range state reads entry 0
  always_comb begin
    cfg_smu = '0;
    for (int m = 0; m < M; m++) begin
      logic [SW-1:0] w_sel;
      w_sel = smu_state[m*SW +: SW];
      if (32'(w_sel) < N) cfg_smu[m*CW +: CW] = r_active[m][w_sel];
      else                cfg_smu[m*CW +: CW] = r_active[m][0];
    end
  end

endmodule

// File: tb/tb_smu_cfg_ctrl.sv
// tb_smu_cfg_ctrl: directed checks of the config stream controller.
// Defaults: N=2 K=4 M=6 DW=8 -> CW=10, two payload beats per entry.
module tb_smu_cfg_ctrl;

  localparam int M  = 6;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [7:0]    cfg_data;
  logic          cfg_last;
  logic [5:0]    smu_state;
  logic [59:0]   cfg_smu;
  logic [5:0]    smu_clr;
  logic          cfg_locked;
  logic          cfg_err;

  int n_chk = 0;
  int n_err = 0;
  int clr_seen = 0;
  int clr_base;

  smu_cfg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .smu_state  (smu_state),
    .cfg_smu    (cfg_smu),
    .smu_clr    (smu_clr),
    .cfg_locked (cfg_locked),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (|smu_clr) clr_seen <= clr_seen + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] unit_cfg(input int m);
    return cfg_smu[m*CW +: CW];
  endfunction

  function automatic logic [7:0] hdr(input logic [1:0] op,
                                     input logic [2:0] u, input logic s);
    return {2'b00, u, s, op};
  endfunction

  // One beat; returns 1 time unit after the accepting edge
  task automatic beat(input logic [7:0] d, input logic l);
    int t;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    t = 0;
    while (!cfg_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) chk("ready_timeout", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] u, input logic s,
                    input logic [7:0] b0, input logic [7:0] b1);
    beat(hdr(2'b00, u, s), 1'b0);
    beat(b0, 1'b0);
    beat(b1, 1'b1);
  endtask

  // Returns in the cycle where smu_clr should be high
  task automatic commit();
    beat(hdr(2'b01, 3'd0, 1'b0), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    smu_state = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cfg_ready), 64'd1);
    chk("rst_smu", 64'(cfg_smu), 64'd0);
    chk("rst_clr", 64'(smu_clr), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_lock", 64'(cfg_locked), 64'd0);
    rst = 1'b0;

    // Basic write then commit
    smu_state = 6'b000100;
    wr(3'd2, 1'b1, 8'hA5, 8'h03);
    chk("pre_commit", 64'(unit_cfg(2)), 64'd0);
    beat(hdr(2'b01, 3'd0, 1'b0), 1'b1);
    chk("commit_ready", 64'(cfg_ready), 64'd0);
    chk("commit_noclr", 64'(smu_clr), 64'd0);
    @(posedge clk);
    #1;
    chk("clr_pulse", 64'(smu_clr), 64'h3F);
    chk("u2_s1", 64'(unit_cfg(2)), 64'h3A5);
    chk("ready_back", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("clr_one_cycle", 64'(smu_clr), 64'd0);
    smu_state = 6'b000000;
    #1;
    chk("u2_s0", 64'(unit_cfg(2)), 64'd0);
    smu_state = 6'b000100;

    // Uncommitted write, then clear + commit
    wr(3'd2, 1'b1, 8'h11, 8'h01);
    chk("no_commit_keep", 64'(unit_cfg(2)), 64'h3A5);
    beat(hdr(2'b10, 3'd0, 1'b0), 1'b1);
    chk("clear_active", 64'(unit_cfg(2)), 64'h3A5);
    commit();
    chk("clear_clr", 64'(smu_clr), 64'h3F);
    chk("clear_all", 64'(cfg_smu), 64'd0);
    chk("err_clean", 64'(cfg_err), 64'd0);

    // Out-of-range unit; stream recovers
    wr(3'd7, 1'b0, 8'hFF, 8'h03);
    chk("bad_unit_err", 64'(cfg_err), 64'd1);
    smu_state = 6'b000000;
    wr(3'd1, 1'b0, 8'h5A, 8'h02);
    commit();
    chk("recover_u1", 64'(unit_cfg(1)), 64'h25A);
    chk("bad_unit_none", 64'(cfg_smu), 64'h25A << CW);

    // Early last on first payload beat
    do_reset();
    wr(3'd0, 1'b0, 8'h77, 8'h01);
    beat(hdr(2'b00, 3'd0, 1'b0), 1'b0);
    beat(8'hFF, 1'b1);
    chk("short_err", 64'(cfg_err), 64'd1);
    commit();
    chk("short_keep", 64'(unit_cfg(0)), 64'h177);

    // WRITE header carrying last
    do_reset();
    beat(hdr(2'b00, 3'd0, 1'b0), 1'b1);
    chk("wr_last_err", 64'(cfg_err), 64'd1);
    commit();
    chk("wr_last_none", 64'(cfg_smu), 64'd0);

    // COMMIT without last goes to drop
    do_reset();
    clr_base = clr_seen;
    beat(hdr(2'b01, 3'd0, 1'b0), 1'b0);
    beat(8'h01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("cmt_nolast_err", 64'(cfg_err), 64'd1);
    chk("cmt_nolast_clr", 64'(clr_seen - clr_base), 64'd0);

    // Lock blocks writes and commits
    do_reset();
    smu_state = 6'b001000;
    wr(3'd3, 1'b1, 8'h3C, 8'h02);
    commit();
    chk("pre_lock", 64'(unit_cfg(3)), 64'h23C);
    beat(hdr(2'b11, 3'd0, 1'b0), 1'b1);
    chk("locked", 64'(cfg_locked), 64'd1);
    chk("lock_noerr", 64'(cfg_err), 64'd0);
    beat(hdr(2'b11, 3'd0, 1'b0), 1'b1);
    chk("relock_noerr", 64'(cfg_err), 64'd0);
    clr_base = clr_seen;
    wr(3'd3, 1'b1, 8'h00, 8'h00);
    chk("lock_wr_err", 64'(cfg_err), 64'd1);
    beat(hdr(2'b01, 3'd0, 1'b0), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("lock_noclr", 64'(clr_seen - clr_base), 64'd0);
    chk("lock_keep", 64'(unit_cfg(3)), 64'h23C);
    chk("lock_sticky", 64'(cfg_locked), 64'd1);

    // Reset in the middle of a payload
    beat(hdr(2'b00, 3'd4, 1'b0), 1'b0);
    beat(8'h12, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_lock", 64'(cfg_locked), 64'd0);
    chk("mid_rst_err", 64'(cfg_err), 64'd0);
    chk("mid_rst_ready", 64'(cfg_ready), 64'd1);
    chk("mid_rst_smu", 64'(cfg_smu), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    smu_state = 6'b000000;
    wr(3'd4, 1'b0, 8'h12, 8'h00);
    commit();
    chk("post_rst_wr", 64'(unit_cfg(4)), 64'h012);
    chk("post_rst_err", 64'(cfg_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
